// File: rtl/shape_calc_engine.sv
// shape_calc_engine: area/perimeter/classification engine with a 16-cycle shift-add multiplier.
// Optional SHAPE_CALC_SAT_FLAG_EN adds an overflow port and saturates results wider than 32 bits.
package shape_processor_modeling;
    typedef enum logic [2:0] {
        KEEP_SHAPE = 3'd0,
        CIRCLE     = 3'd1,
        RECTANGLE  = 3'd2,
        TRIANGLE   = 3'd3
    } shape_e;
    typedef enum logic [2:0] {
        KEEP_OPERATION = 3'd0,
        AREA           = 3'd1,
        PERIMETER      = 3'd2,
        IS_SQUARE      = 3'd3,
        IS_EQUILATERAL = 3'd4,
        IS_ISOSCELES   = 3'd5
    } operation_e;
    function automatic logic is_legal_combination(input shape_e s, input operation_e o);
        case (s)
            CIRCLE:    return o inside {AREA, PERIMETER};
            RECTANGLE: return o inside {AREA, PERIMETER, IS_SQUARE};
            TRIANGLE:  return o inside {AREA, PERIMETER, IS_EQUILATERAL, IS_ISOSCELES};
            default:   return 1'b0;
        endcase
    endfunction
endpackage

module shape_calc_engine
    import shape_processor_modeling::*;
#(
    parameter logic [15:0] PI_Q8 = 16'd804
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  shape_e      shape,
    input  operation_e  operation,
    input  logic [15:0] op_a,
    input  logic [15:0] op_b,
    input  logic [15:0] op_c,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        error
`ifdef SHAPE_CALC_SAT_FLAG_EN
    ,
    output logic        overflow
`endif
);
    typedef enum logic [2:0] {IDLE, CHECK, MUL1, MUL2, DONE} state_e;
    state_e      state_q, state_d;
    shape_e      shape_q, shape_d;
    operation_e  op_q, op_d;
    logic [15:0] a_q, a_d, b_q, b_d, c_q, c_d, mplier_q, mplier_d;
    logic [31:0] mcand_q, mcand_d, result_q, result_d, quick, fin;
    logic [47:0] acc_q, acc_d, prod;
    logic [3:0]  cnt_q, cnt_d;
    logic        error_q, error_d, ovf_q, ovf_d;
    logic [16:0] ab, ac, bc;
    logic        tri_bad, reject, multi, in_cp;

    assign ab      = {1'b0, a_q} + {1'b0, b_q};
    assign ac      = {1'b0, a_q} + {1'b0, c_q};
    assign bc      = {1'b0, b_q} + {1'b0, c_q};
    assign tri_bad = ab <= {1'b0, c_q} || ac <= {1'b0, b_q} || bc <= {1'b0, a_q};
    assign reject  = !is_legal_combination(shape_q, op_q) || (shape_q == TRIANGLE && (op_q == AREA || tri_bad));
    assign multi   = op_q == AREA || (shape_q == CIRCLE && op_q == PERIMETER);
    assign in_cp   = shape == CIRCLE && operation == PERIMETER;
    assign quick   = shape_q == RECTANGLE && op_q == PERIMETER ? {14'd0, ab, 1'b0} :
                     op_q == PERIMETER      ? {15'd0, ab} + {16'd0, c_q} :
                     op_q == IS_SQUARE      ? {31'd0, a_q == b_q} :
                     op_q == IS_EQUILATERAL ? {31'd0, a_q == b_q && b_q == c_q} :
                                              {31'd0, a_q == b_q || b_q == c_q || a_q == c_q};
    // One partial product per cycle, weighted by the step count
    assign prod    = acc_q + (mplier_q[0] ? {16'd0, mcand_q} << cnt_q : 48'd0);
`ifdef SHAPE_CALC_SAT_FLAG_EN
    logic [39:0] scaled;
    assign scaled  = shape_q == CIRCLE ? prod[47:8] : prod[39:0];
    assign fin     = |scaled[39:32] ? 32'hFFFF_FFFF : scaled[31:0];
    assign ovf_d   = state_d == DONE && state_q != DONE ? state_q != CHECK && |scaled[39:32] : ovf_q;
    assign overflow = ovf_q;
`else
    assign fin     = shape_q == CIRCLE ? prod[39:8] : prod[31:0];
    assign ovf_d   = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        shape_d  = shape_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        error_d  = error_q;
        if (state_q inside {CHECK, MUL1, MUL2}) begin
            acc_d    = prod;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 4'd1;
        end
        case (state_q)
            IDLE: if (start) begin
                state_d  = CHECK;
                shape_d  = shape;
                op_d     = operation;
                a_d      = op_a;
                b_d      = op_b;
                c_d      = op_c;
                mcand_d  = in_cp ? {15'd0, op_a, 1'b0} : {16'd0, op_a};
                mplier_d = in_cp ? PI_Q8 : shape == CIRCLE ? op_a : op_b;
                acc_d    = 48'd0;
                cnt_d    = 4'd0;
            end
            CHECK: begin
                state_d  = reject || !multi ? DONE : MUL1;
                result_d = reject ? 32'd0 : quick;
                error_d  = reject;
            end
            MUL1: if (cnt_q == 4'd15) begin
                if (shape_q == CIRCLE && op_q == AREA) begin
                    state_d  = MUL2;
                    mcand_d  = prod[31:0];
                    mplier_d = PI_Q8;
                    acc_d    = 48'd0;
                end else begin
                    state_d  = DONE;
                    result_d = fin;
                    error_d  = 1'b0;
                end
            end
            MUL2: if (cnt_q == 4'd15) begin
                state_d  = DONE;
                result_d = fin;
                error_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            shape_q  <= KEEP_SHAPE;
            op_q     <= KEEP_OPERATION;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            error_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shape_q  <= shape_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            error_q  <= error_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy   = state_q inside {CHECK, MUL1, MUL2};
    assign done   = state_q == DONE;
    assign result = result_q;
    assign error  = error_q;
endmodule

// File: tb/tb_shape_calc_engine.sv
// tb_shape_calc_engine: directed vectors against an arithmetic reference model of shape_calc_engine.
module tb_shape_calc_engine;
    import shape_processor_modeling::*;
    localparam logic [63:0] PI = 64'd804;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    shape_e      shape = KEEP_SHAPE;
    operation_e  operation = KEEP_OPERATION;
    logic [15:0] op_a = '0, op_b = '0, op_c = '0;
    logic        busy, done, error;
    logic [31:0] result;
`ifdef SHAPE_CALC_SAT_FLAG_EN
    logic        overflow;
`endif

    shape_calc_engine dut (
        .clk(clk), .rst_n(rst_n), .start(start), .shape(shape), .operation(operation),
        .op_a(op_a), .op_b(op_b), .op_c(op_c), .busy(busy), .done(done), .result(result),
        .error(error)
`ifdef SHAPE_CALC_SAT_FLAG_EN
        , .overflow(overflow)
`endif
    );

    always #5 clk = ~clk;

    int          total = 0, bad = 0;
    int          cyc = 0, exp_lat = 0, got_cyc = -1;
    logic        active = 1'b0, exp_err = 1'b0, exp_ov = 1'b0, got_err = 1'b0;
    logic [31:0] exp_res = '0, got_res = '0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: what each request must produce, straight from the shape formulas
    function automatic void model(input shape_e s, input operation_e o, input logic [15:0] a, b, c,
                                  output int lat, output logic [31:0] r, output logic e, output logic ov);
        logic [63:0] v;
        logic        tri_ok;
        tri_ok = int'(a) + int'(b) > int'(c) && int'(a) + int'(c) > int'(b) && int'(b) + int'(c) > int'(a);
        lat = 2; e = 1'b0; ov = 1'b0; v = '0;
        if (s == CIRCLE && o == AREA) begin v = (64'(a) * a * PI) >> 8; lat = 33; end
        else if (s == CIRCLE && o == PERIMETER) begin v = (64'(a) * 2 * PI) >> 8; lat = 17; end
        else if (s == RECTANGLE && o == AREA) begin v = 64'(a) * b; lat = 17; end
        else if (s == RECTANGLE && o == PERIMETER) v = 2 * (64'(a) + b);
        else if (s == RECTANGLE && o == IS_SQUARE) v = 64'(a == b);
        else if (s == TRIANGLE && tri_ok && o == PERIMETER) v = 64'(a) + b + c;
        else if (s == TRIANGLE && tri_ok && o == IS_EQUILATERAL) v = 64'(a == b && b == c);
        else if (s == TRIANGLE && tri_ok && o == IS_ISOSCELES) v = 64'(a == b || b == c || a == c);
        else e = 1'b1;
        r = v[31:0];
`ifdef SHAPE_CALC_SAT_FLAG_EN
        if (v > 64'hFFFF_FFFF) begin r = 32'hFFFF_FFFF; ov = 1'b1; end
`endif
        if (e) r = '0;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_busy", {31'd0, busy}, 0);
            chk("rst_done", {31'd0, done}, 0);
            chk("rst_result", result, 0);
            chk("rst_error", {31'd0, error}, 0);
        end else if (active) begin
            cyc++;
            chk($sformatf("busy@%0d", cyc), {31'd0, busy}, {31'd0, cyc < exp_lat});
            chk($sformatf("done@%0d", cyc), {31'd0, done}, {31'd0, cyc == exp_lat});
            if (done) begin
                got_cyc = cyc; got_res = result; got_err = error;
                chk("result", result, exp_res);
                chk("error", {31'd0, error}, {31'd0, exp_err});
`ifdef SHAPE_CALC_SAT_FLAG_EN
                chk("overflow", {31'd0, overflow}, {31'd0, exp_ov});
`endif
            end
            if (cyc >= exp_lat) active = 1'b0;
        end else begin
            chk("idle_busy", {31'd0, busy}, 0);
            chk("idle_done", {31'd0, done}, 0);
        end
    end

    task automatic launch(input shape_e s, input operation_e o, input logic [15:0] a, b, c);
        @(negedge clk);
        shape = s; operation = o; op_a = a; op_b = b; op_c = c; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        model(s, o, a, b, c, exp_lat, exp_res, exp_err, exp_ov);
        op_a = 16'($urandom); op_b = 16'($urandom); op_c = 16'($urandom);
        cyc = 0; got_cyc = -1; active = 1'b1;
    endtask

    task automatic finish_req;
        for (int i = 0; i < 60 && active; i++) @(negedge clk);
        if (active) begin
            total++; bad++;
            $display("FAIL timeout: got busy %0b expected completion", busy);
            active = 1'b0;
        end
    endtask

    task automatic run(input shape_e s, input operation_e o, input logic [15:0] a, b, c);
        launch(s, o, a, b, c);
        finish_req();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        run(RECTANGLE, AREA, 3, 5, 0);
        chk("pin_rect_area", got_res, 15);
        chk("pin_rect_area_cyc", got_cyc, 17);
        run(CIRCLE, AREA, 10, 0, 0);
        chk("pin_circ_area", got_res, 314);
        chk("pin_circ_area_cyc", got_cyc, 33);
        run(CIRCLE, PERIMETER, 10, 0, 0);
        chk("pin_circ_perim", got_res, 62);
        chk("pin_circ_perim_cyc", got_cyc, 17);
        run(TRIANGLE, PERIMETER, 3, 4, 5);
        chk("pin_tri_perim", got_res, 12);
        chk("pin_tri_perim_cyc", got_cyc, 2);
        run(TRIANGLE, IS_ISOSCELES, 1, 2, 3);
        chk("pin_tri_degen_err", {31'd0, got_err}, 1);
        chk("pin_tri_degen_res", got_res, 0);
        run(KEEP_SHAPE, AREA, 3, 4, 5);
        chk("pin_keep_shape_err", {31'd0, got_err}, 1);
        chk("pin_keep_shape_cyc", got_cyc, 2);
        run(RECTANGLE, operation_e'(3'd6), 3, 4, 5);
        chk("pin_rsvd_op_err", {31'd0, got_err}, 1);
        run(RECTANGLE, IS_EQUILATERAL, 4, 4, 4);
        chk("pin_rect_equi_err", {31'd0, got_err}, 1);
        run(RECTANGLE, PERIMETER, 7, 9, 0);
        run(RECTANGLE, IS_SQUARE, 4, 4, 0);
        run(RECTANGLE, IS_SQUARE, 4, 5, 0);
        run(TRIANGLE, IS_EQUILATERAL, 5, 5, 5);
        run(TRIANGLE, IS_ISOSCELES, 5, 5, 8);
        run(TRIANGLE, IS_ISOSCELES, 4, 5, 6);
        run(TRIANGLE, AREA, 3, 4, 5);
        run(TRIANGLE, PERIMETER, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        run(CIRCLE, AREA, 0, 0, 0);
        run(CIRCLE, PERIMETER, 0, 0, 0);
        run(RECTANGLE, AREA, 0, 1234, 0);
        run(RECTANGLE, AREA, 16'hFFFF, 16'hFFFF, 0);
        run(CIRCLE, IS_SQUARE, 2, 2, 0);
        run(shape_e'(3'd5), AREA, 1, 1, 1);
        run(CIRCLE, KEEP_OPERATION, 1, 1, 1);
        run(CIRCLE, AREA, 16'hFFFF, 0, 0);
`ifdef SHAPE_CALC_SAT_FLAG_EN
        chk("pin_circ_sat", got_res, 32'hFFFF_FFFF);
`else
        chk("pin_circ_trunc", got_res, 32'h23F9_B803);
`endif
        launch(RECTANGLE, AREA, 3, 5, 0);
        repeat (4) @(posedge clk);
        #1 start = 1'b1; shape = CIRCLE; operation = AREA; op_a = 16'd99;
        @(posedge clk);
        #1 start = 1'b0;
        finish_req();
        chk("pin_repulse_res", got_res, 15);
        chk("pin_repulse_cyc", got_cyc, 17);
        repeat (5) @(negedge clk);
        launch(CIRCLE, AREA, 10, 0, 0);
        repeat (7) @(posedge clk);
        #1 rst_n = 1'b0; active = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (40) @(negedge clk);
        run(TRIANGLE, PERIMETER, 3, 4, 5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/shape_calc_engine.md
SHAPE_CALC_ENGINE -- requirements
Module: shape_calc_engine

Interface
REQ-001 Parameter PI_Q8, default 804, unsigned 16-bit Q8.8 pi constant used for circle operations.
REQ-002 Port clk  in  1  single clock; all state updates on posedge.
REQ-003 Port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 Port start  in  1  request to compute; sampled only in IDLE.
REQ-005 Port shape  in  shape_e  from shape_processor_modeling; the shape field of the control SFR.
REQ-006 Port operation  in  operation_e  from shape_processor_modeling; the operation field of the control SFR.
REQ-007 Ports op_a, op_b, op_c  in  16 each  unsigned dimensions: circle r=op_a; rectangle w=op_a, h=op_b; triangle sides a,b,c.
REQ-008 Port busy  out  1  high from the cycle after start is accepted until done.
REQ-009 Port done  out  1  single-cycle completion pulse.
REQ-010 Port result  out  32  unsigned result, held from done until the next accepted start.
REQ-011 Port error  out  1  valid with done; high = request rejected, result=0.

Function
REQ-012 FSM states: IDLE, CHECK, MUL1, MUL2, DONE; start in IDLE -> CHECK, latching shape, operation and operands.
REQ-013 start while busy or in DONE: ignored, no effect on latched values.
REQ-014 CHECK rejects (-> DONE, error=1): reserved shape or operation, KEEP_SHAPE, KEEP_OPERATION, !is_legal_combination(shape,operation), TRIANGLE+AREA, and triangle with a+b<=c, a+c<=b or b+c<=a (17-bit sums).
REQ-015 CHECK single-cycle ops -> DONE: RECTANGLE PERIMETER=2*(w+h); TRIANGLE PERIMETER=a+b+c; IS_SQUARE=(w==h); IS_EQUILATERAL=(a==b&&b==c); IS_ISOSCELES=(a==b||b==c||a==c). Boolean results are 0/1.
REQ-016 Multiplier: iterative shift-add, 32-bit multiplicand x 16-bit multiplier, 1 bit/cycle, exactly 16 cycles per pass, 48-bit accumulator.
REQ-017 RECTANGLE AREA = w*h: one pass (MUL1).
REQ-018 CIRCLE PERIMETER = (2r*PI_Q8)>>8: one pass (MUL1).
REQ-019 CIRCLE AREA = ((r*r)*PI_Q8)>>8: pass 1 in MUL1, pass 2 in MUL2 with the 32-bit r*r as multiplicand.
REQ-020 Latency from start-accepted cycle (cycle 0) to done: 2 cycles for rejected/single-cycle ops, 17 for one pass, 33 for two passes.
REQ-021 DONE lasts one cycle, asserts done, then -> IDLE; busy deasserts in the same cycle done asserts.
REQ-022 Zero operands are legal for circle/rectangle and produce 0.
REQ-023 Inputs other than start are don't-care outside the start-accepted cycle.

Reset
REQ-024 rst_n low: state=IDLE, busy=0, done=0, error=0, result=0, multiplier cleared, regardless of state.
REQ-025 Reset mid-computation aborts it; no done pulse is produced for the aborted request.

Configuration
REQ-026 Macro SHAPE_CALC_SAT_FLAG_EN defined: extra port overflow (out, 1, valid with done); results exceeding 32 bits saturate to 32'hFFFF_FFFF with overflow=1, else overflow=0.
REQ-027 Macro not defined: no overflow port; oversized results are truncated to their low 32 bits.

Verification
REQ-028 RECTANGLE AREA w=3 h=5 -> done at cycle 17, result=15, error=0.
REQ-029 CIRCLE AREA r=10, PI_Q8=804 -> done at cycle 33, result=314; CIRCLE PERIMETER r=10 -> cycle 17, result=62.
REQ-030 TRIANGLE PERIMETER 3,4,5 -> cycle 2, result=12; TRIANGLE IS_ISOSCELES 1,2,3 -> cycle 2, error=1, result=0.
REQ-031 start re-pulsed at cycle 5 of a rectangle area -> ignored, single done at cycle 17; rst_n low at cycle 8 of a second request -> busy=0 next cycle, no done.
REQ-032 CIRCLE AREA r=16'hFFFF -> with SHAPE_CALC_SAT_FLAG_EN result=32'hFFFF_FFFF, overflow=1; without it, result=low 32 bits of ((65535*65535)*804)>>8.
REQ-033 KEEP_SHAPE, reserved operation, and RECTANGLE+IS_EQUILATERAL each -> done at cycle 2 with error=1.
